// File: rtl/qpsk_symbol_mapper.sv
// Ping-pong bit buffer behind the 802.16 block interleaver; drains each full block in index
// order as Gray-coded QPSK symbols with a valid/ready handshake toward the IFFT.
module qpsk_symbol_mapper #(
    parameter int unsigned NCBPS = 192,
    parameter int unsigned W     = 16,
    parameter int unsigned AMP   = 23170
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     valid_in,
    input  logic                     data_in,
    input  logic [$clog2(NCBPS)-1:0] data_in_index,
    output logic                     ready_mod,
    input  logic                     ready_ds,
    output logic                     valid_mod,
    output logic [W-1:0]             i_out,
    output logic [W-1:0]             q_out,
    output logic                     sym_first
);

    localparam int unsigned IW   = $clog2(NCBPS);
    localparam int unsigned NSYM = NCBPS / 2;
    localparam int unsigned RW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [W-1:0] POS = W'(AMP);
    localparam logic [W-1:0] NEG = ~POS + W'(1);

    logic [NCBPS-1:0] bank [2];

    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [IW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  i_q, i_d;
    logic [W-1:0]  q_q, q_d;
    logic          first_q, first_d;

    logic          accept;
    logic          in_range;
    logic          wr_last;
    logic          load;
    logic          rd_last;
    logic [RW:0]   rd_addr;
    logic          b0;
    logic          b1;

    assign ready_mod = !bank_full_q[wr_sel_q];
    assign valid_mod = valid_q;
    assign i_out     = i_q;
    assign q_out     = q_q;
    assign sym_first = first_q;

    always_comb begin
        accept   = valid_in & ready_mod;
        // Out-of-range indices still count toward the block so it closes after NCBPS accepts.
        in_range = ({1'b0, data_in_index} < (IW + 1)'(NCBPS));
        wr_last  = accept && (wr_cnt_q == IW'(NCBPS - 1));
        load     = bank_full_q[rd_sel_q] & (!valid_q | ready_ds);
        rd_last  = load && (rd_ptr_q == RW'(NSYM - 1));
        rd_addr  = {rd_ptr_q, 1'b0};
        b0       = bank[rd_sel_q][rd_addr];
        b1       = bank[rd_sel_q][rd_addr + 1'b1];

        wr_cnt_d = wr_cnt_q;
        if (accept) begin
            wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
        end
        wr_sel_d = wr_sel_q ^ wr_last;

        rd_ptr_d = rd_ptr_q;
        if (load) begin
            rd_ptr_d = rd_last ? '0 : rd_ptr_q + 1'b1;
        end
        rd_sel_d = rd_sel_q ^ rd_last;

        // Set and clear always hit different banks, so both apply.
        bank_full_d = bank_full_q;
        if (wr_last) begin
            bank_full_d[wr_sel_q] = 1'b1;
        end
        if (rd_last) begin
            bank_full_d[rd_sel_q] = 1'b0;
        end

        valid_d = valid_q;
        i_d     = i_q;
        q_d     = q_q;
        first_d = first_q;
        if (load) begin
            valid_d = 1'b1;
            i_d     = b0 ? NEG : POS;
            q_d     = b1 ? NEG : POS;
            first_d = (rd_ptr_q == '0);
        end else if (ready_ds) begin
            valid_d = 1'b0;
            first_d = 1'b0;
        end
    end

    // Buffer storage is not reset; bank_full gates every read of stale contents.
    always_ff @(posedge clk) begin
        if (accept && in_range) begin
            bank[wr_sel_q][data_in_index] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            bank_full_q <= 2'b00;
            valid_q     <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            first_q     <= 1'b0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            bank_full_q <= bank_full_d;
            valid_q     <= valid_d;
            i_q         <= i_d;
            q_q         <= q_d;
            first_q     <= first_d;
        end
    end

endmodule
